axil_arb_2x1: RTL and testbench
===============================

# axil_arb_2x1

Two-requester AXI-Lite arbiter that shares a single AXI-Lite slave, such as the frame buffer RAM, between two masters, such as the core-side crossbar port and a video scanout or GPU engine. It grants one complete transaction at a time (read or write), round-robin between requesters, and registers the address and write phases toward the shared slave. Only one transaction is ever outstanding downstream, so no ID tracking or reordering is needed.

## Interface
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width on all ports
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- clk  in  1  single clock domain; all ports synchronous to it
- rst  in  1  asynchronous, active-high reset
- sN_axil_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1  write address from requester N (N = 0, 1); sN_axil_awready  out  1
- sN_axil_wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1  write data; sN_axil_wready  out  1
- sN_axil_bresp/bvalid  out  2/1  write response; sN_axil_bready  in  1
- sN_axil_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1  read address; sN_axil_arready  out  1
- sN_axil_rdata/rresp/rvalid  out  DATA_WIDTH/2/1  read data; sN_axil_rready  in  1
- m_axil_aw*, w*, b*, ar*, r*  mirror of one sN port with directions reversed, toward the shared slave

## Operation
- Request of requester N: req_N = arvalid_N | (awvalid_N & wvalid_N). A lone awvalid or a lone wvalid is not a request and is not accepted.
- Arbitration runs only in IDLE:
  - If both requesters request, grant the one that is not last_grant.
  - If one requests, grant it.
  - Within the granted requester, a read wins over a write if both are pending.
  - last_grant updates to the winner on each grant.
- States:
  - IDLE: for the winner, pulse arready, or awready and wready together, for one cycle. Latch addr/prot (and data/strb for a write) into holding registers. Go to RADDR or WADDR.
  - RADDR: m_arvalid=1 from the holding register. On m_arready, go to RDATA.
  - RDATA: combinational pass-through: sG_rdata/rresp/rvalid = m_r*, m_rready = sG_rready. Non-granted rvalid=0. On m_rvalid & m_rready, go to IDLE.
  - WADDR: m_awvalid and m_wvalid start at 1. Each drops independently on its own handshake. When both are done, go to WRESP.
  - WRESP: pass-through of b* between m and sG. On m_bvalid & m_bready, go to IDLE.
- The non-granted requester sees all ready/valid outputs at 0 for the whole transaction.
- Response codes (bresp/rresp) are forwarded unmodified; the arbiter never generates SLVERR.

## Timing
- Reset values:
  - all sN ready/valid outputs and all m valid/ready outputs are 0
  - state = IDLE, last_grant = 1 (so requester 0 wins the first tie)
  - holding registers = 0
- Read, with the slave ready and responding one cycle later: accept at cycle 0, m_arvalid at cycle 1, m_rvalid and sG_rvalid at cycle 2, IDLE at cycle 3.
  - Minimum turnaround is 3 cycles per transaction.
  - The next grant can be issued in the IDLE cycle that follows.
- Write: accept at cycle 0, AW/W at cycle 1 onward, B forwarded in the cycle m_bvalid rises.
- m_* address and data outputs are registered; the r/b return paths are combinational, with zero added latency.
- Holding registers do not change outside IDLE; new requests wait, and upstream valid is held per AXI rules.
- Back-pressure:
  - if sG_rready=0 or sG_bready=0, the FSM stays in RDATA or WRESP indefinitely.
  - if the slave never asserts ready, the FSM stays in RADDR or WADDR indefinitely; there is no timeout.
- Reset asserted mid-transaction forces IDLE immediately. The in-flight transaction is abandoned, and the shared slave is reset by the same rst.

## Structure
- Package axil_arb_pkg:
  - typedef enum state_t {IDLE, RADDR, RDATA, WADDR, WRESP}
  - localparams for the AXI response codes OKAY=2'b00 and SLVERR=2'b10
- Sub-module rr_arb2: inputs req[1:0], last_grant, en; outputs grant, valid. Purely combinational, and reusable by other shared resources.
- Top-level: one FSM, holding registers, aw_done/w_done flags, and output muxes keyed by the registered grant.

## Test plan
- Single read, s0 araddr=0x0000_0040, slave returns 0xDEAD_BEEF after 1 cycle:
  - s0_rdata=0xDEAD_BEEF, rresp=0, at cycle 2.
  - s1 sees no valid at any point.
- Simultaneous s0 and s1 reads straight out of reset: s0 granted first, s1 second; a repeat of both gives s0 then s1 again (strict alternation).
- s1 write awaddr=0x10, wdata=0x1234_5678, wstrb=0xF, with m_awready at cycle 1 and m_wready at cycle 3:
  - m_awvalid drops after cycle 1, m_wvalid after cycle 3.
  - bresp=0 is delivered to s1 only.
- s0 asserts arvalid and awvalid+wvalid together: the read completes first, then the write on the next grant.
- s0_rready held at 0 for 5 cycles while s1 requests: s1 waits, and the grant to s1 is issued only after the s0 R handshake.
- rst pulsed while in WADDR: all outputs return to 0 asynchronously, state returns to IDLE, and a new s1 read then completes normally.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-requester AXI-Lite arbiter.
package axil_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WRESP
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // A write only counts as a request once both address and data are offered.
    function automatic logic is_req(input logic arvalid, input logic awvalid, input logic wvalid);
        return arvalid | (awvalid & wvalid);
    endfunction

endpackage

// File: rtl/axil_arb_2x1_rr_arb2.sv
// Combinational two-way round-robin picker; on a tie the side that did not win last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = en & (|req);
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/axil_arb_2x1.sv
// Shares one AXI-Lite slave between two masters, one complete read or write at a time.
// Address/data toward the slave come from holding registers; r/b return paths are combinational.
module axil_arb_2x1
    import axil_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
    input  logic [2:0]            s0_axil_awprot,
    input  logic                  s0_axil_awvalid,
    output logic                  s0_axil_awready,
    input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
    input  logic                  s0_axil_wvalid,
    output logic                  s0_axil_wready,
    output logic [1:0]            s0_axil_bresp,
    output logic                  s0_axil_bvalid,
    input  logic                  s0_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
    input  logic [2:0]            s0_axil_arprot,
    input  logic                  s0_axil_arvalid,
    output logic                  s0_axil_arready,
    output logic [DATA_WIDTH-1:0] s0_axil_rdata,
    output logic [1:0]            s0_axil_rresp,
    output logic                  s0_axil_rvalid,
    input  logic                  s0_axil_rready,

    input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
    input  logic [2:0]            s1_axil_awprot,
    input  logic                  s1_axil_awvalid,
    output logic                  s1_axil_awready,
    input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
    input  logic                  s1_axil_wvalid,
    output logic                  s1_axil_wready,
    output logic [1:0]            s1_axil_bresp,
    output logic                  s1_axil_bvalid,
    input  logic                  s1_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
    input  logic [2:0]            s1_axil_arprot,
    input  logic                  s1_axil_arvalid,
    output logic                  s1_axil_arready,
    output logic [DATA_WIDTH-1:0] s1_axil_rdata,
    output logic [1:0]            s1_axil_rresp,
    output logic                  s1_axil_rvalid,
    input  logic                  s1_axil_rready,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    state_t                state;
    state_t                state_nxt;
    logic                  gnt;
    logic                  last_grant;
    logic                  aw_done;
    logic                  w_done;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [2:0]            hold_prot;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [STRB_WIDTH-1:0] hold_strb;

    logic [1:0]            req;
    logic                  arb_grant;
    logic                  arb_valid;
    logic                  win_rd;
    logic [ADDR_WIDTH-1:0] win_araddr;
    logic [ADDR_WIDTH-1:0] win_awaddr;
    logic [2:0]            win_arprot;
    logic [2:0]            win_awprot;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [STRB_WIDTH-1:0] win_wstrb;
    logic                  sel_rready;
    logic                  sel_bready;

    logic [1:0]            arready_v;
    logic [1:0]            awready_v;
    logic [1:0]            wready_v;
    logic [1:0]            rvalid_v;
    logic [1:0]            bvalid_v;

    assign req[0] = is_req(s0_axil_arvalid, s0_axil_awvalid, s0_axil_wvalid);
    assign req[1] = is_req(s1_axil_arvalid, s1_axil_awvalid, s1_axil_wvalid);

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant),
        .en         (state == IDLE),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Winner-side request fields, only meaningful while arb_valid is high in IDLE.
    assign win_rd     = arb_grant ? s1_axil_arvalid : s0_axil_arvalid;
    assign win_araddr = arb_grant ? s1_axil_araddr  : s0_axil_araddr;
    assign win_arprot = arb_grant ? s1_axil_arprot  : s0_axil_arprot;
    assign win_awaddr = arb_grant ? s1_axil_awaddr  : s0_axil_awaddr;
    assign win_awprot = arb_grant ? s1_axil_awprot  : s0_axil_awprot;
    assign win_wdata  = arb_grant ? s1_axil_wdata   : s0_axil_wdata;
    assign win_wstrb  = arb_grant ? s1_axil_wstrb   : s0_axil_wstrb;

    assign sel_rready = gnt ? s1_axil_rready : s0_axil_rready;
    assign sel_bready = gnt ? s1_axil_bready : s0_axil_bready;

    always_comb begin
        state_nxt      = state;
        arready_v      = '0;
        awready_v      = '0;
        wready_v       = '0;
        rvalid_v       = '0;
        bvalid_v       = '0;
        m_axil_arvalid = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_rready  = 1'b0;
        m_axil_bready  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    if (win_rd) begin
                        arready_v[arb_grant] = 1'b1;
                        state_nxt            = RADDR;
                    end else begin
                        awready_v[arb_grant] = 1'b1;
                        wready_v[arb_grant]  = 1'b1;
                        state_nxt            = WADDR;
                    end
                end
            end
            RADDR: begin
                m_axil_arvalid = 1'b1;
                if (m_axil_arready) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                rvalid_v[gnt] = m_axil_rvalid;
                m_axil_rready = sel_rready;
                if (m_axil_rvalid && sel_rready) begin
                    state_nxt = IDLE;
                end
            end
            WADDR: begin
                m_axil_awvalid = ~aw_done;
                m_axil_wvalid  = ~w_done;
                if ((aw_done || m_axil_awready) && (w_done || m_axil_wready)) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                bvalid_v[gnt] = m_axil_bvalid;
                m_axil_bready = sel_bready;
                if (m_axil_bvalid && sel_bready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            hold_addr  <= '0;
            hold_prot  <= '0;
            hold_data  <= '0;
            hold_strb  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && arb_valid) begin
                gnt        <= arb_grant;
                last_grant <= arb_grant;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
                hold_addr  <= win_rd ? win_araddr : win_awaddr;
                hold_prot  <= win_rd ? win_arprot : win_awprot;
                if (!win_rd) begin
                    hold_data <= win_wdata;
                    hold_strb <= win_wstrb;
                end
            end
            // AW and W complete independently; each valid drops after its own handshake.
            if (state == WADDR) begin
                if (m_axil_awvalid && m_axil_awready) begin
                    aw_done <= 1'b1;
                end
                if (m_axil_wvalid && m_axil_wready) begin
                    w_done <= 1'b1;
                end
            end
        end
    end

    assign m_axil_araddr = hold_addr;
    assign m_axil_arprot = hold_prot;
    assign m_axil_awaddr = hold_addr;
    assign m_axil_awprot = hold_prot;
    assign m_axil_wdata  = hold_data;
    assign m_axil_wstrb  = hold_strb;

    assign s0_axil_arready = arready_v[0];
    assign s0_axil_awready = awready_v[0];
    assign s0_axil_wready  = wready_v[0];
    assign s0_axil_rvalid  = rvalid_v[0];
    assign s0_axil_bvalid  = bvalid_v[0];
    assign s1_axil_arready = arready_v[1];
    assign s1_axil_awready = awready_v[1];
    assign s1_axil_wready  = wready_v[1];
    assign s1_axil_rvalid  = rvalid_v[1];
    assign s1_axil_bvalid  = bvalid_v[1];

    // Response payloads go to both sides; only the granted side ever sees a valid.
    assign s0_axil_rdata = m_axil_rdata;
    assign s0_axil_rresp = m_axil_rresp;
    assign s0_axil_bresp = m_axil_bresp;
    assign s1_axil_rdata = m_axil_rdata;
    assign s1_axil_rresp = m_axil_rresp;
    assign s1_axil_bresp = m_axil_bresp;

endmodule

// File: tb/tb_axil_arb_2x1.sv
// Bench for axil_arb_2x1: two scripted masters, a simple slave model, and a scoreboard of expected responses.
module tb_axil_arb_2x1;
    import axil_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] s0_axil_awaddr, s0_axil_wdata, s0_axil_araddr, s0_axil_rdata;
    logic [2:0]  s0_axil_awprot, s0_axil_arprot;
    logic [3:0]  s0_axil_wstrb;
    logic [1:0]  s0_axil_bresp, s0_axil_rresp;
    logic        s0_axil_awvalid, s0_axil_awready, s0_axil_wvalid, s0_axil_wready;
    logic        s0_axil_bvalid, s0_axil_bready, s0_axil_arvalid, s0_axil_arready;
    logic        s0_axil_rvalid, s0_axil_rready;

    logic [31:0] s1_axil_awaddr, s1_axil_wdata, s1_axil_araddr, s1_axil_rdata;
    logic [2:0]  s1_axil_awprot, s1_axil_arprot;
    logic [3:0]  s1_axil_wstrb;
    logic [1:0]  s1_axil_bresp, s1_axil_rresp;
    logic        s1_axil_awvalid, s1_axil_awready, s1_axil_wvalid, s1_axil_wready;
    logic        s1_axil_bvalid, s1_axil_bready, s1_axil_arvalid, s1_axil_arready;
    logic        s1_axil_rvalid, s1_axil_rready;

    logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic [3:0]  m_axil_wstrb;
    logic [1:0]  m_axil_bresp, m_axil_rresp;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic        m_axil_rvalid, m_axil_rready;

    axil_arb_2x1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .s0_axil_awaddr(s0_axil_awaddr), .s0_axil_awprot(s0_axil_awprot),
        .s0_axil_awvalid(s0_axil_awvalid), .s0_axil_awready(s0_axil_awready),
        .s0_axil_wdata(s0_axil_wdata), .s0_axil_wstrb(s0_axil_wstrb),
        .s0_axil_wvalid(s0_axil_wvalid), .s0_axil_wready(s0_axil_wready),
        .s0_axil_bresp(s0_axil_bresp), .s0_axil_bvalid(s0_axil_bvalid), .s0_axil_bready(s0_axil_bready),
        .s0_axil_araddr(s0_axil_araddr), .s0_axil_arprot(s0_axil_arprot),
        .s0_axil_arvalid(s0_axil_arvalid), .s0_axil_arready(s0_axil_arready),
        .s0_axil_rdata(s0_axil_rdata), .s0_axil_rresp(s0_axil_rresp),
        .s0_axil_rvalid(s0_axil_rvalid), .s0_axil_rready(s0_axil_rready),
        .s1_axil_awaddr(s1_axil_awaddr), .s1_axil_awprot(s1_axil_awprot),
        .s1_axil_awvalid(s1_axil_awvalid), .s1_axil_awready(s1_axil_awready),
        .s1_axil_wdata(s1_axil_wdata), .s1_axil_wstrb(s1_axil_wstrb),
        .s1_axil_wvalid(s1_axil_wvalid), .s1_axil_wready(s1_axil_wready),
        .s1_axil_bresp(s1_axil_bresp), .s1_axil_bvalid(s1_axil_bvalid), .s1_axil_bready(s1_axil_bready),
        .s1_axil_araddr(s1_axil_araddr), .s1_axil_arprot(s1_axil_arprot),
        .s1_axil_arvalid(s1_axil_arvalid), .s1_axil_arready(s1_axil_arready),
        .s1_axil_rdata(s1_axil_rdata), .s1_axil_rresp(s1_axil_rresp),
        .s1_axil_rvalid(s1_axil_rvalid), .s1_axil_rready(s1_axil_rready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: read data and response derived from the address, one-cycle latency.
    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [1:0] slv_resp(input logic [31:0] a);
        return a[8] ? SLVERR : OKAY;
    endfunction

    logic        slv_ar_rdy, slv_aw_rdy, slv_w_rdy;
    logic        got_aw, got_w;
    logic [31:0] last_waddr, last_wdata;
    logic [3:0]  last_wstrb;
    logic        aw_hs, w_hs;

    assign m_axil_arready = slv_ar_rdy;
    assign m_axil_awready = slv_aw_rdy;
    assign m_axil_wready  = slv_w_rdy;
    assign aw_hs = m_axil_awvalid & m_axil_awready;
    assign w_hs  = m_axil_wvalid & m_axil_wready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axil_rvalid <= 1'b0;
            m_axil_rdata  <= '0;
            m_axil_rresp  <= '0;
            m_axil_bvalid <= 1'b0;
            m_axil_bresp  <= '0;
            got_aw        <= 1'b0;
            got_w         <= 1'b0;
            last_waddr    <= '0;
            last_wdata    <= '0;
            last_wstrb    <= '0;
        end else begin
            if (m_axil_rvalid && m_axil_rready) m_axil_rvalid <= 1'b0;
            if (m_axil_arvalid && m_axil_arready) begin
                m_axil_rvalid <= 1'b1;
                m_axil_rdata  <= slv_data(m_axil_araddr);
                m_axil_rresp  <= slv_resp(m_axil_araddr);
            end
            if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;
            if (aw_hs) last_waddr <= m_axil_awaddr;
            if (w_hs) begin
                last_wdata <= m_axil_wdata;
                last_wstrb <= m_axil_wstrb;
            end
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                m_axil_bvalid <= 1'b1;
                m_axil_bresp  <= slv_resp(aw_hs ? m_axil_awaddr : last_waddr);
                got_aw        <= 1'b0;
                got_w         <= 1'b0;
            end else begin
                if (aw_hs) got_aw <= 1'b1;
                if (w_hs)  got_w  <= 1'b1;
            end
        end
    end

    typedef struct {
        bit          port;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } item_t;

    item_t sb[$];

    task automatic push(input bit p, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
        item_t it;
        it.port = p; it.rd = rd; it.addr = a; it.data = d; it.strb = s; it.resp = r;
        sb.push_back(it);
    endtask

    task automatic sb_pop(input bit p, input bit rd, input logic [31:0] d, input logic [1:0] r);
        item_t it;
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
        end else begin
            it = sb.pop_front();
            chk("sb_port", p, it.port);
            chk("sb_kind", rd, it.rd);
            chk("sb_resp", r, it.resp);
            if (rd) begin
                chk("sb_rdata", d, it.data);
            end else begin
                chk("sb_waddr", last_waddr, it.addr);
                chk("sb_wdata", last_wdata, it.data);
                chk("sb_wstrb", last_wstrb, it.strb);
            end
        end
    endtask

    logic [14:0] all_outs;
    logic        s0_any, s1_any;
    int          excl = 0;
    int          s1_leak = 0;
    int          cur_test = 0;

    assign s0_any = s0_axil_arready | s0_axil_awready | s0_axil_wready | s0_axil_rvalid | s0_axil_bvalid;
    assign s1_any = s1_axil_arready | s1_axil_awready | s1_axil_wready | s1_axil_rvalid | s1_axil_bvalid;
    assign all_outs = {s0_axil_arready, s0_axil_awready, s0_axil_wready, s0_axil_rvalid, s0_axil_bvalid,
                       s1_axil_arready, s1_axil_awready, s1_axil_wready, s1_axil_rvalid, s1_axil_bvalid,
                       m_axil_arvalid, m_axil_awvalid, m_axil_wvalid, m_axil_rready, m_axil_bready};

    always @(negedge clk) begin
        if (!rst) begin
            if (s0_any && s1_any) excl++;
            if (cur_test == 1 && s1_any) s1_leak++;
            if (s0_axil_rvalid && s0_axil_rready) sb_pop(1'b0, 1'b1, s0_axil_rdata, s0_axil_rresp);
            if (s1_axil_rvalid && s1_axil_rready) sb_pop(1'b1, 1'b1, s1_axil_rdata, s1_axil_rresp);
            if (s0_axil_bvalid && s0_axil_bready) sb_pop(1'b0, 1'b0, 32'h0, s0_axil_bresp);
            if (s1_axil_bvalid && s1_axil_bready) sb_pop(1'b1, 1'b0, 32'h0, s1_axil_bresp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input bit p, input bit arv, input logic [31:0] ra, input bit wv,
                              input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
        if (!p) begin
            s0_axil_arvalid = arv; s0_axil_araddr = ra; s0_axil_arprot = 3'b000;
            s0_axil_awvalid = wv;  s0_axil_awaddr = wa; s0_axil_awprot = 3'b000;
            s0_axil_wvalid  = wv;  s0_axil_wdata  = wd; s0_axil_wstrb  = ws;
        end else begin
            s1_axil_arvalid = arv; s1_axil_araddr = ra; s1_axil_arprot = 3'b000;
            s1_axil_awvalid = wv;  s1_axil_awaddr = wa; s1_axil_awprot = 3'b000;
            s1_axil_wvalid  = wv;  s1_axil_wdata  = wd; s1_axil_wstrb  = ws;
        end
    endtask

    // Holds each requested valid until its handshake, as an AXI master must.
    task automatic master_req(input bit p, input bit rd, input bit wr, input logic [31:0] ra,
                              input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
        bit rpend, wpend, ar_ok, aw_ok;
        int k;
        rpend = rd;
        wpend = wr;
        k = 0;
        drive_port(p, rpend, ra, wpend, wa, wd, ws);
        while ((rpend || wpend) && k < 200) begin
            @(negedge clk);
            ar_ok = rpend && (p ? s1_axil_arready : s0_axil_arready);
            aw_ok = wpend && (p ? (s1_axil_awready && s1_axil_wready)
                                : (s0_axil_awready && s0_axil_wready));
            @(posedge clk);
            #1;
            if (ar_ok) rpend = 1'b0;
            if (aw_ok) wpend = 1'b0;
            drive_port(p, rpend, ra, wpend, wa, wd, ws);
            k++;
        end
        chk("req_accept", {rpend, wpend}, 2'b00);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain", sb.size(), 0);
        step();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int bp_leak = 0;
    int bp_rv = 0;

    initial begin
        drive_port(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_port(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        s0_axil_rready = 1'b1; s0_axil_bready = 1'b1;
        s1_axil_rready = 1'b1; s1_axil_bready = 1'b1;
        slv_ar_rdy = 1'b1; slv_aw_rdy = 1'b1; slv_w_rdy = 1'b1;
        reset_dut();

        // Reset state
        @(negedge clk);
        chk("rst_outs", all_outs, 15'h0);
        chk("rst_araddr", m_axil_araddr, 32'h0);
        chk("rst_wdata", m_axil_wdata, 32'h0);

        // Single read from s0, cycle by cycle
        cur_test = 1;
        push(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'h0, OKAY);
        step();
        s0_axil_araddr = 32'h40; s0_axil_arprot = 3'b010; s0_axil_arvalid = 1'b1;
        @(negedge clk);
        chk("t1_arready", s0_axil_arready, 1'b1);
        step();
        s0_axil_arvalid = 1'b0;
        @(negedge clk);
        chk("t1_m_arvalid", m_axil_arvalid, 1'b1);
        chk("t1_m_araddr", m_axil_araddr, 32'h40);
        chk("t1_m_arprot", m_axil_arprot, 3'b010);
        step();
        @(negedge clk);
        chk("t1_rvalid", s0_axil_rvalid, 1'b1);
        chk("t1_rdata", s0_axil_rdata, 32'hDEAD_BEEF);
        chk("t1_rresp", s0_axil_rresp, OKAY);
        step();
        @(negedge clk);
        chk("t1_rvalid_done", s0_axil_rvalid, 1'b0);
        cur_test = 0;
        chk("t1_s1_quiet", s1_leak, 0);
        drain();

        // Simultaneous reads out of reset, twice: strict alternation starting at s0
        reset_dut();
        for (int r = 0; r < 2; r++) begin
            push(1'b0, 1'b1, 32'h100 + 32'(r * 4), slv_data(32'h100 + 32'(r * 4)), 4'h0, SLVERR);
            push(1'b1, 1'b1, 32'h200 + 32'(r * 4), slv_data(32'h200 + 32'(r * 4)), 4'h0, OKAY);
            fork
                master_req(1'b0, 1'b1, 1'b0, 32'h100 + 32'(r * 4), 32'h0, 32'h0, 4'h0);
                master_req(1'b1, 1'b1, 1'b0, 32'h200 + 32'(r * 4), 32'h0, 32'h0, 4'h0);
            join
            drain();
        end

        // s1 write with AW accepted at cycle 1 and W at cycle 3
        slv_aw_rdy = 1'b0; slv_w_rdy = 1'b0;
        push(1'b1, 1'b0, 32'h10, 32'h1234_5678, 4'hF, OKAY);
        step();
        s1_axil_awaddr = 32'h10; s1_axil_awprot = 3'b001; s1_axil_awvalid = 1'b1;
        s1_axil_wdata = 32'h1234_5678; s1_axil_wstrb = 4'hF; s1_axil_wvalid = 1'b1;
        @(negedge clk);
        chk("t3_accept", {s1_axil_awready, s1_axil_wready, s0_axil_awready}, 3'b110);
        step();
        s1_axil_awvalid = 1'b0; s1_axil_wvalid = 1'b0; slv_aw_rdy = 1'b1;
        @(negedge clk);
        chk("t3_c1_valid", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
        chk("t3_awaddr", m_axil_awaddr, 32'h10);
        chk("t3_awprot", m_axil_awprot, 3'b001);
        chk("t3_wdata", m_axil_wdata, 32'h1234_5678);
        chk("t3_wstrb", m_axil_wstrb, 4'hF);
        step();
        slv_aw_rdy = 1'b0;
        @(negedge clk);
        chk("t3_c2_valid", {m_axil_awvalid, m_axil_wvalid}, 2'b01);
        step();
        slv_w_rdy = 1'b1;
        @(negedge clk);
        chk("t3_c3_valid", {m_axil_awvalid, m_axil_wvalid}, 2'b01);
        step();
        @(negedge clk);
        chk("t3_c4_valid", {m_axil_awvalid, m_axil_wvalid}, 2'b00);
        chk("t3_bvalid", {s1_axil_bvalid, s0_axil_bvalid}, 2'b10);
        chk("t3_bresp", s1_axil_bresp, OKAY);
        slv_aw_rdy = 1'b1;
        drain();

        // s0 read and write together: read first, write on the next grant
        push(1'b0, 1'b1, 32'h44, slv_data(32'h44), 4'h0, OKAY);
        push(1'b0, 1'b0, 32'h104, 32'hCAFE_F00D, 4'h3, SLVERR);
        master_req(1'b0, 1'b1, 1'b1, 32'h44, 32'h104, 32'hCAFE_F00D, 4'h3);
        drain();

        // s0 stalls its R channel while s1 waits
        push(1'b0, 1'b1, 32'h48, slv_data(32'h48), 4'h0, OKAY);
        push(1'b1, 1'b1, 32'h4C, slv_data(32'h4C), 4'h0, OKAY);
        s0_axil_rready = 1'b0;
        fork
            master_req(1'b0, 1'b1, 1'b0, 32'h48, 32'h0, 32'h0, 4'h0);
            begin
                step();
                step();
                master_req(1'b1, 1'b1, 1'b0, 32'h4C, 32'h0, 32'h0, 4'h0);
            end
            begin
                step();
                step();
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (s1_axil_arready) bp_leak++;
                    if (s0_axil_rvalid) bp_rv++;
                end
                step();
                s0_axil_rready = 1'b1;
            end
        join
        chk("t5_s1_wait", bp_leak, 0);
        chk("t5_rvalid_held", bp_rv, 5);
        drain();

        // Asynchronous reset while in WADDR, then a clean s1 read
        slv_aw_rdy = 1'b0; slv_w_rdy = 1'b0;
        step();
        drive_port(1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 32'h5555_AAAA, 4'hF);
        @(negedge clk);
        chk("t6_accept", s1_axil_awready, 1'b1);
        step();
        drive_port(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t6_waddr", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_outs", all_outs, 15'h0);
        chk("t6_rst_hold", m_axil_awaddr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        slv_aw_rdy = 1'b1; slv_w_rdy = 1'b1;
        push(1'b1, 1'b1, 32'h50, slv_data(32'h50), 4'h0, OKAY);
        master_req(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 32'h0, 4'h0);
        drain();

        chk("exclusive_grant", excl, 0);
        chk("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
